// File: rtl/dec3l_cfg_sequencer_pkg.sv
// rtl/dec3l_cfg_sequencer_pkg.sv - decoder topology/commutation types, level codes and sequencer states
`ifndef TDELAY_WIDTH
`define TDELAY_WIDTH 10
`endif

package PKG_decoder_3lxnpc;

  typedef enum logic [1:0] {
    NoOut = 2'd0,
    NPC   = 2'd1,
    ANPC  = 2'd2,
    TNPC  = 2'd3
  } _npctypes_t;

  typedef enum logic [1:0] {
    COMM_OUTER = 2'd0,
    COMM_INNER = 2'd1,
    COMM_FULL  = 2'd2,
    COMM_MIXED = 2'd3
  } _commtypes_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ARM   = 3'd2,
    RUN   = 3'd3,
    ZERO  = 3'd4,
    BLANK = 3'd5
  } _seqstate_t;

  localparam logic [1:0] LEV_NEG  = 2'b00;
  localparam logic [1:0] LEV_ZERO = 2'b01;
  localparam logic [1:0] LEV_POS  = 2'b10;

  // The unused code 2'b11 must never reach the gates as anything but zero level.
  function automatic logic [1:0] lev_sanitize(input logic [1:0] lev);
    return (lev == 2'b11) ? LEV_ZERO : lev;
  endfunction

endpackage

// File: rtl/dec3l_cfg_sequencer_dwell.sv
// rtl/dec3l_cfg_sequencer_dwell.sv - shared dwell counter, done after max(t,1) cycles from load
module dwell_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] t,
  output logic             done
);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] last;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      last  <= '0;
    end else if (load) begin
      count <= '0;
      last  <= (t == '0) ? '0 : t - 1'b1;
    end else if (count != last) begin
      count <= count + 1'b1;
    end
  end

  assign done = (count == last);

endmodule

// File: rtl/dec3l_cfg_sequencer.sv
// rtl/dec3l_cfg_sequencer.sv - glitch-safe run-time reconfiguration sequencer in front of decoder_3lxnpc
`ifndef TDELAY_WIDTH
`define TDELAY_WIDTH 10
`endif

module dec3l_cfg_sequencer
  import PKG_decoder_3lxnpc::*;
#(
  parameter int CNT_W = 16,
  parameter int TD_W  = `TDELAY_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_apply,
  input  _npctypes_t       req_npc_type,
  input  _commtypes_t      req_comm_type,
  input  logic [TD_W-1:0]  req_t_short,
  input  logic [TD_W-1:0]  req_t_off_on,
  input  logic [TD_W-1:0]  req_t_on_offV0,
  input  logic [TD_W-1:0]  req_t_offV0_on,
  input  logic [TD_W-1:0]  req_t_off_onI0,
  input  logic [CNT_W-1:0] t_settle,
  input  logic [CNT_W-1:0] t_blank,
  input  logic [1:0]       v_lev_in,
  output _npctypes_t       npc_type,
  output _commtypes_t      comm_type_anpc,
  output logic [TD_W-1:0]  t_short,
  output logic [TD_W-1:0]  t_off_on,
  output logic [TD_W-1:0]  t_on_offV0,
  output logic [TD_W-1:0]  t_offV0_on,
  output logic [TD_W-1:0]  t_off_onI0,
  output logic [1:0]       v_lev,
  output logic             busy,
  output logic             running,
  output logic             cfg_done,
  output logic             apply_rejected
);

  _seqstate_t state, next_state;
  logic stop_q, stop_d;
  logic accept, reject, shadow_we;
  logic dwell_load, dwell_done;
  logic [CNT_W-1:0] dwell_t;

  _npctypes_t pend_npc;
  _commtypes_t pend_comm;
  logic [4:0][TD_W-1:0] pend_t;
  logic [4:0][TD_W-1:0] req_t;

  assign req_t = {req_t_off_onI0, req_t_offV0_on, req_t_on_offV0, req_t_off_on, req_t_short};

  dwell_counter #(.CNT_W(CNT_W)) u_dwell (
    .clk  (clk),
    .rst  (rst),
    .load (dwell_load),
    .t    (dwell_t),
    .done (dwell_done)
  );

  always_comb begin
    next_state = state;
    stop_d     = stop_q;
    accept     = 1'b0;
    reject     = 1'b0;
    shadow_we  = 1'b0;
    case (state)
      IDLE: begin
        if (cfg_apply) begin
          if (en) begin
            next_state = LOAD;
            accept     = 1'b1;
          end else begin
            reject = 1'b1;
          end
        end
      end
      LOAD: begin
        reject    = cfg_apply;
        shadow_we = 1'b1;
        if (!en) begin
          next_state = ZERO;
          stop_d     = 1'b1;
        end else begin
          next_state = ARM;
        end
      end
      ARM: begin
        reject = cfg_apply;
        if (!en) begin
          next_state = ZERO;
          stop_d     = 1'b1;
        end else if (dwell_done) begin
          next_state = RUN;
        end
      end
      RUN: begin
        // A stop request outranks a simultaneous reconfiguration.
        if (!en) begin
          next_state = ZERO;
          stop_d     = 1'b1;
          reject     = cfg_apply;
        end else if (cfg_apply) begin
          next_state = ZERO;
          stop_d     = 1'b0;
          accept     = 1'b1;
        end
      end
      ZERO: begin
        reject = cfg_apply;
        if (!en) stop_d = 1'b1;
        if (dwell_done) next_state = BLANK;
      end
      BLANK: begin
        reject = cfg_apply;
        if (!en) stop_d = 1'b1;
        if (dwell_done) next_state = (stop_q || !en) ? IDLE : LOAD;
      end
      default: next_state = IDLE;
    endcase
    if (next_state == IDLE) stop_d = 1'b0;
    dwell_load = (next_state != state) && (next_state inside {ARM, ZERO, BLANK});
    dwell_t    = (next_state == BLANK) ? t_blank : t_settle;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      stop_q         <= 1'b0;
      pend_npc       <= NoOut;
      pend_comm      <= COMM_OUTER;
      pend_t         <= '0;
      npc_type       <= NoOut;
      comm_type_anpc <= COMM_OUTER;
      t_short        <= '0;
      t_off_on       <= '0;
      t_on_offV0     <= '0;
      t_offV0_on     <= '0;
      t_off_onI0     <= '0;
      v_lev          <= LEV_ZERO;
      busy           <= 1'b0;
      running        <= 1'b0;
      cfg_done       <= 1'b0;
      apply_rejected <= 1'b0;
    end else begin
      state  <= next_state;
      stop_q <= stop_d;
      if (accept) begin
        pend_npc  <= req_npc_type;
        pend_comm <= req_comm_type;
        pend_t    <= req_t;
      end
      if (shadow_we) begin
        comm_type_anpc <= pend_comm;
        t_short        <= pend_t[0];
        t_off_on       <= pend_t[1];
        t_on_offV0     <= pend_t[2];
        t_offV0_on     <= pend_t[3];
        t_off_onI0     <= pend_t[4];
      end
      // The topology only goes live once the level is already pinned at zero.
      if (state == LOAD && next_state == ARM) begin
        npc_type <= pend_npc;
      end else if (next_state != state && (next_state inside {BLANK, IDLE, LOAD})) begin
        npc_type <= NoOut;
      end
      v_lev          <= (next_state == RUN) ? lev_sanitize(v_lev_in) : LEV_ZERO;
      busy           <= !(next_state inside {IDLE, RUN});
      running        <= (next_state == RUN);
      cfg_done       <= (next_state == RUN) && (state != RUN);
      apply_rejected <= reject;
    end
  end

endmodule

// File: tb/tb_dec3l_cfg_sequencer.sv
// tb/tb_dec3l_cfg_sequencer.sv - self-checking bench for dec3l_cfg_sequencer
module tb_dec3l_cfg_sequencer;
  import PKG_decoder_3lxnpc::*;

  localparam int CNT_W = 16;
  localparam int TD_W  = 10;

  logic clk = 1'b0;
  logic rst, en, cfg_apply;
  _npctypes_t req_npc_type;
  _commtypes_t req_comm_type;
  logic [TD_W-1:0] req_t_short, req_t_off_on, req_t_on_offV0, req_t_offV0_on, req_t_off_onI0;
  logic [CNT_W-1:0] t_settle, t_blank;
  logic [1:0] v_lev_in;
  _npctypes_t npc_type;
  _commtypes_t comm_type_anpc;
  logic [TD_W-1:0] t_short, t_off_on, t_on_offV0, t_offV0_on, t_off_onI0;
  logic [1:0] v_lev;
  logic busy, running, cfg_done, apply_rejected;

  dec3l_cfg_sequencer #(.CNT_W(CNT_W), .TD_W(TD_W)) dut (
    .clk(clk), .rst(rst), .en(en), .cfg_apply(cfg_apply),
    .req_npc_type(req_npc_type), .req_comm_type(req_comm_type),
    .req_t_short(req_t_short), .req_t_off_on(req_t_off_on), .req_t_on_offV0(req_t_on_offV0),
    .req_t_offV0_on(req_t_offV0_on), .req_t_off_onI0(req_t_off_onI0),
    .t_settle(t_settle), .t_blank(t_blank), .v_lev_in(v_lev_in),
    .npc_type(npc_type), .comm_type_anpc(comm_type_anpc),
    .t_short(t_short), .t_off_on(t_off_on), .t_on_offV0(t_on_offV0),
    .t_offV0_on(t_offV0_on), .t_off_onI0(t_off_onI0),
    .v_lev(v_lev), .busy(busy), .running(running), .cfg_done(cfg_done),
    .apply_rejected(apply_rejected)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase plus remaining dwell cycles, updated from the sequencing rules.
  typedef enum {P_IDLE, P_LOAD, P_ARM, P_RUN, P_ZERO, P_BLANK} phase_t;
  typedef struct {
    _npctypes_t npc;
    _commtypes_t comm;
    logic [TD_W-1:0] t[5];
  } cfg_t;

  phase_t m_ph;
  int m_rem;
  bit m_stop;
  cfg_t m_pend, m_shadow;
  _npctypes_t e_npc;
  logic [1:0] e_vlev;
  bit e_rej, e_done;

  function automatic int dwell(input logic [CNT_W-1:0] t);
    return (t == 0) ? 1 : int'(t);
  endfunction

  function automatic cfg_t cur_req();
    cfg_t c;
    c.npc = req_npc_type;
    c.comm = req_comm_type;
    c.t[0] = req_t_short; c.t[1] = req_t_off_on; c.t[2] = req_t_on_offV0;
    c.t[3] = req_t_offV0_on; c.t[4] = req_t_off_onI0;
    return c;
  endfunction

  function automatic cfg_t zero_cfg();
    cfg_t c;
    c.npc = NoOut;
    c.comm = COMM_OUTER;
    for (int i = 0; i < 5; i++) c.t[i] = '0;
    return c;
  endfunction

  task automatic model_step();
    bit s;
    e_rej = 0;
    e_done = 0;
    if (rst) begin
      m_ph = P_IDLE; m_rem = 0; m_stop = 0;
      m_pend = zero_cfg(); m_shadow = zero_cfg(); e_npc = NoOut;
    end else begin
      case (m_ph)
        P_IDLE: if (cfg_apply) begin
          if (en) begin m_pend = cur_req(); m_ph = P_LOAD; end
          else e_rej = 1;
        end
        P_LOAD: begin
          e_rej = cfg_apply;
          m_shadow = m_pend;
          m_rem = dwell(t_settle);
          if (!en) begin m_ph = P_ZERO; m_stop = 1; end
          else begin m_ph = P_ARM; e_npc = m_pend.npc; end
        end
        P_ARM: begin
          e_rej = cfg_apply;
          if (!en) begin m_ph = P_ZERO; m_stop = 1; m_rem = dwell(t_settle); end
          else if (m_rem == 1) begin m_ph = P_RUN; e_done = 1; end
          else m_rem--;
        end
        P_RUN: begin
          if (!en) begin
            e_rej = cfg_apply; m_ph = P_ZERO; m_stop = 1; m_rem = dwell(t_settle);
          end else if (cfg_apply) begin
            m_pend = cur_req(); m_ph = P_ZERO; m_stop = 0; m_rem = dwell(t_settle);
          end
        end
        P_ZERO: begin
          e_rej = cfg_apply;
          if (!en) m_stop = 1;
          if (m_rem == 1) begin m_ph = P_BLANK; m_rem = dwell(t_blank); e_npc = NoOut; end
          else m_rem--;
        end
        default: begin
          e_rej = cfg_apply;
          s = m_stop || !en;
          m_stop = s;
          if (m_rem == 1) begin
            m_ph = s ? P_IDLE : P_LOAD;
            e_npc = NoOut;
            if (s) m_stop = 0;
          end else m_rem--;
        end
      endcase
    end
    e_vlev = (m_ph == P_RUN) ? ((v_lev_in == 2'b11) ? 2'b01 : v_lev_in) : 2'b01;
  endtask

  task automatic model_check();
    chk("m_npc", npc_type, e_npc);
    chk("m_comm", comm_type_anpc, m_shadow.comm);
    chk("m_t_short", t_short, m_shadow.t[0]);
    chk("m_t_off_on", t_off_on, m_shadow.t[1]);
    chk("m_t_on_offV0", t_on_offV0, m_shadow.t[2]);
    chk("m_t_offV0_on", t_offV0_on, m_shadow.t[3]);
    chk("m_t_off_onI0", t_off_onI0, m_shadow.t[4]);
    chk("m_vlev", v_lev, e_vlev);
    chk("m_busy", busy, (m_ph != P_IDLE && m_ph != P_RUN));
    chk("m_running", running, (m_ph == P_RUN));
    chk("m_cfg_done", cfg_done, e_done);
    chk("m_rejected", apply_rejected, e_rej);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    model_check();
  endtask

  task automatic run_until_running(input string name);
    int n = 0;
    while (!running && n < 60) begin tick(); n++; end
    chk(name, running, 1);
  endtask

  typedef struct { logic [1:0] vin; logic [1:0] vexp; } lev_vec_t;
  typedef struct { logic [CNT_W-1:0] ts; logic [CNT_W-1:0] tb; int nz; int nb; int na; } dw_vec_t;

  lev_vec_t lv[5];
  dw_vec_t dw[4];

  initial begin
    _npctypes_t cur, nxt;
    logic [1:0] prev;
    int n;

    lv[0] = '{2'b10, 2'b10}; lv[1] = '{2'b11, 2'b01}; lv[2] = '{2'b00, 2'b00};
    lv[3] = '{2'b01, 2'b01}; lv[4] = '{2'b11, 2'b01};
    dw[0] = '{16'd3, 16'd5, 3, 5, 3}; dw[1] = '{16'd0, 16'd0, 1, 1, 1};
    dw[2] = '{16'd1, 16'd2, 1, 2, 1}; dw[3] = '{16'd2, 16'd0, 2, 1, 2};

    rst = 1; en = 0; cfg_apply = 0; req_npc_type = NoOut; req_comm_type = COMM_OUTER;
    req_t_short = 0; req_t_off_on = 0; req_t_on_offV0 = 0; req_t_offV0_on = 0; req_t_off_onI0 = 0;
    t_settle = 0; t_blank = 0; v_lev_in = 2'b00;
    @(negedge clk);
    tick();
    chk("rst_npc", npc_type, NoOut);
    chk("rst_vlev", v_lev, 2'b01);
    chk("rst_busy", busy, 0);
    chk("rst_running", running, 0);
    chk("rst_t_short", t_short, 0);
    rst = 0;
    tick();

    // Initial configuration: LOAD 1 cycle, ARM 4 cycles, cfg_done on RUN entry.
    en = 1; cfg_apply = 1; req_npc_type = NPC; req_comm_type = COMM_FULL; req_t_short = 10;
    req_t_off_on = 11; req_t_on_offV0 = 12; req_t_offV0_on = 13; req_t_off_onI0 = 14;
    t_settle = 4; t_blank = 2;
    tick();
    cfg_apply = 0; req_t_short = 7; req_npc_type = TNPC;
    chk("load_busy", busy, 1);
    chk("load_npc", npc_type, NoOut);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("arm_npc", npc_type, NPC);
      chk("arm_vlev", v_lev, 2'b01);
      chk("arm_done", cfg_done, 0);
      chk("arm_t_short", t_short, 10);
      tick();
    end
    chk("run_done", cfg_done, 1);
    chk("run_running", running, 1);
    tick();
    chk("run_done_pulse", cfg_done, 0);

    prev = 2'b00;
    for (int i = 0; i < 5; i++) begin
      v_lev_in = lv[i].vin;
      chk("lev_latency", v_lev, prev);
      tick();
      chk("lev_map", v_lev, lv[i].vexp);
      prev = lv[i].vexp;
    end

    cur = NPC;
    for (int i = 0; i < 4; i++) begin
      nxt = (cur == NPC) ? ANPC : NPC;
      t_settle = dw[i].ts; t_blank = dw[i].tb; req_npc_type = nxt; cfg_apply = 1;
      tick();
      cfg_apply = 0;
      n = 0;
      while (busy && npc_type == cur && n < 40) begin chk("zero_vlev", v_lev, 2'b01); n++; tick(); end
      chk("zero_len", n, dw[i].nz);
      n = 0;
      while (busy && npc_type == NoOut && n < 40) begin chk("blank_vlev", v_lev, 2'b01); n++; tick(); end
      chk("blank_len", n - 1, dw[i].nb);
      n = 0;
      while (busy && npc_type == nxt && n < 40) begin chk("arm_new_vlev", v_lev, 2'b01); n++; tick(); end
      chk("arm_len", n, dw[i].na);
      chk("dw_running", running, 1);
      chk("dw_npc", npc_type, nxt);
      cur = nxt;
    end

    // Apply during BLANK is rejected and does not disturb the pending configuration.
    nxt = (cur == NPC) ? ANPC : NPC;
    t_settle = 1; t_blank = 4; req_npc_type = nxt; req_t_short = 20; cfg_apply = 1;
    tick();
    cfg_apply = 0;
    tick();
    chk("blank_state", npc_type, NoOut);
    req_npc_type = TNPC; req_t_short = 99; cfg_apply = 1;
    tick();
    cfg_apply = 0;
    chk("rej_pulse", apply_rejected, 1);
    tick();
    chk("rej_pulse_end", apply_rejected, 0);
    run_until_running("rej_reach_run");
    chk("rej_cfg_npc", npc_type, nxt);
    chk("rej_cfg_t_short", t_short, 20);
    cur = nxt;

    // en falling during ARM: ZERO, BLANK, then IDLE.
    nxt = (cur == NPC) ? ANPC : NPC;
    t_settle = 3; t_blank = 1; req_npc_type = nxt; cfg_apply = 1;
    tick();
    cfg_apply = 0;
    n = 0;
    while (!(busy && npc_type == nxt) && n < 40) begin tick(); n++; end
    chk("reach_arm", npc_type, nxt);
    en = 0;
    tick();
    chk("stop_zero_npc", npc_type, nxt);
    chk("stop_zero_vlev", v_lev, 2'b01);
    n = 0;
    while (busy && n < 40) begin chk("stop_not_run", running, 0); tick(); n++; end
    chk("stop_len", n, 4);
    chk("stop_idle_npc", npc_type, NoOut);
    chk("stop_idle_running", running, 0);

    // Reset in the middle of BLANK.
    en = 1; t_settle = 0; t_blank = 6; req_npc_type = TNPC; req_t_short = 33; cfg_apply = 1;
    tick();
    cfg_apply = 0;
    run_until_running("rb_reach_run");
    cfg_apply = 1;
    tick();
    cfg_apply = 0;
    tick();
    chk("rb_blank_npc", npc_type, NoOut);
    chk("rb_pre_t_short", t_short, 33);
    rst = 1;
    tick();
    rst = 0;
    chk("rb_npc", npc_type, NoOut);
    chk("rb_t_short", t_short, 0);
    chk("rb_busy", busy, 0);
    chk("rb_vlev", v_lev, 2'b01);

    // Simultaneous apply and stop in RUN.
    t_settle = 2; t_blank = 2; cfg_apply = 1;
    tick();
    cfg_apply = 0;
    run_until_running("both_reach_run");
    cfg_apply = 1; en = 0;
    tick();
    cfg_apply = 0;
    chk("both_rej", apply_rejected, 1);
    chk("both_busy", busy, 1);
    n = 0;
    while (busy && n < 40) begin tick(); n++; end
    chk("both_idle_running", running, 0);
    chk("both_idle_npc", npc_type, NoOut);

    rst = 1;
    tick();
    rst = 0;
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      en = ($urandom_range(0, 19) != 0);
      cfg_apply = ($urandom_range(0, 7) == 0);
      req_npc_type = _npctypes_t'($urandom_range(0, 3));
      req_comm_type = _commtypes_t'($urandom_range(0, 3));
      req_t_short = TD_W'($urandom); req_t_off_on = TD_W'($urandom);
      req_t_on_offV0 = TD_W'($urandom); req_t_offV0_on = TD_W'($urandom);
      req_t_off_onI0 = TD_W'($urandom);
      t_settle = CNT_W'($urandom_range(0, 4));
      t_blank = CNT_W'($urandom_range(0, 4));
      v_lev_in = 2'($urandom_range(0, 3));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
